// File: rtl/rambyte_pkg.sv
// Shared types and constants for the byte-masked RAM with hardware clear.
package rambyte_pkg;

    typedef enum logic {
        CLR = 1'b0,
        RDY = 1'b1
    } clr_state_t;

    localparam string MODE_READFIRST  = "READFIRST";
    localparam string MODE_WRITEFIRST = "WRITEFIRST";

endpackage

// File: rtl/rambyte_if.sv
// Request/response bundle between a RAM client (master) and rambyte_init (slave).
interface rambyte_if #(
    parameter int DW = 32,
    parameter int AW = 10,
    parameter int BW = 8
);
    import rambyte_pkg::*;

    logic             ce;
    logic [DW/BW-1:0] we;
    logic [AW-1:0]    addr;
    logic [DW-1:0]    din;
    logic [DW-1:0]    dout;
    logic             dvalid;
    logic             busy;

    modport master (
        output ce, we, addr, din,
        input  dout, dvalid, busy
    );

    modport slave (
        input  ce, we, addr, din,
        output dout, dvalid, busy
    );

endinterface

// File: rtl/rambyte_clr.sv
// Post-reset clear sequencer: walks every address once, then parks in RDY.
module rambyte_clr
    import rambyte_pkg::*;
#(
    parameter int AW    = 10,
    parameter bit CLEAR = 1'b1
) (
    input  logic          clk,
    input  logic          nreset,
    output logic          busy_o,
    output logic [AW-1:0] clr_addr_o,
    output logic          clr_we_o
);

    clr_state_t    state_q;
    logic [AW-1:0] cnt_q;
    logic          busy_q;

    // The edge that writes the last address also leaves CLR, so busy drops the next cycle.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= CLEAR ? CLR : RDY;
            cnt_q   <= '0;
            busy_q  <= CLEAR;
        end else begin
            case (state_q)
                CLR: begin
                    if (cnt_q == '1) begin
                        state_q <= RDY;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + AW'(1);
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign clr_addr_o = cnt_q;
    assign clr_we_o   = busy_q;

endmodule

// File: rtl/rambyte_init.sv
// Single-port RAM with per-lane write mask, read-on-every-access, optional output
// register and hardware zero-initialisation after reset.
module rambyte_init
    import rambyte_pkg::*;
#(
    parameter int    DW    = 32,
    parameter int    AW    = 10,
    parameter int    BW    = 8,
    parameter string MODE  = "READFIRST",
    parameter int    OREG  = 0,
    parameter int    CLEAR = 1
) (
    input  logic     clk,
    input  logic     nreset,
    rambyte_if.slave bus
);

    localparam int LANES = DW / BW;
    localparam int DEPTH = 1 << AW;
    localparam bit WF    = (MODE == MODE_WRITEFIRST);

    logic [DW-1:0] mem [DEPTH];

    logic          busy;
    logic          clr_we;
    logic [AW-1:0] clr_addr;
    logic          accept;
    logic [DW-1:0] rd_word;

    function automatic logic [DW-1:0] lane_merge(input logic [DW-1:0]    old_w,
                                                 input logic [DW-1:0]    new_w,
                                                 input logic [LANES-1:0] mask);
        lane_merge = old_w;
        for (int i = 0; i < LANES; i++) begin
            if (mask[i]) lane_merge[i*BW +: BW] = new_w[i*BW +: BW];
        end
    endfunction

    rambyte_clr #(
        .AW    (AW),
        .CLEAR (CLEAR != 0)
    ) u_clr (
        .clk        (clk),
        .nreset     (nreset),
        .busy_o     (busy),
        .clr_addr_o (clr_addr),
        .clr_we_o   (clr_we)
    );

    assign accept = bus.ce & ~busy;

    // Storage has no reset; the clear walk owns the write port while busy.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (accept) begin
            for (int i = 0; i < LANES; i++) begin
                if (bus.we[i]) mem[bus.addr][i*BW +: BW] <= bus.din[i*BW +: BW];
            end
        end
    end

    assign rd_word = WF ? lane_merge(mem[bus.addr], bus.din, bus.we) : mem[bus.addr];

    // Stage p0: array read captured on accept.
    logic [DW-1:0] rd_p0_q;
    logic          vld_p0_q;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rd_p0_q  <= '0;
            vld_p0_q <= 1'b0;
        end else begin
            vld_p0_q <= accept;
            if (accept) rd_p0_q <= rd_word;
        end
    end

    // Stage p1: optional output register, valid travels with the data.
    generate
        if (OREG != 0) begin : g_oreg
            logic [DW-1:0] dout_p1_q;
            logic          vld_p1_q;

            always_ff @(posedge clk or negedge nreset) begin
                if (!nreset) begin
                    dout_p1_q <= '0;
                    vld_p1_q  <= 1'b0;
                end else begin
                    vld_p1_q <= vld_p0_q;
                    if (vld_p0_q) dout_p1_q <= rd_p0_q;
                end
            end

            assign bus.dout   = dout_p1_q;
            assign bus.dvalid = vld_p1_q;
        end else begin : g_noreg
            assign bus.dout   = rd_p0_q;
            assign bus.dvalid = vld_p0_q;
        end
    endgenerate

    assign bus.busy = busy;

endmodule

// File: tb/tb_rambyte_init.sv
// Bench for rambyte_init: a READFIRST/OREG=0 and a WRITEFIRST/OREG=1 instance share stimulus.
module tb_rambyte_init;

    logic        clk = 1'b0;
    logic        nreset;
    logic        ce;
    logic [3:0]  we;
    logic [3:0]  addr;
    logic [31:0] din;
    logic [31:0] exp_cur [2];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int pulses [2];
    logic [31:0] last_dout [2];

    always #5 clk = ~clk;

    rambyte_if #(.DW(32), .AW(4), .BW(8)) ifa ();
    rambyte_if #(.DW(32), .AW(4), .BW(8)) ifb ();

    assign ifa.ce = ce;  assign ifa.we = we;  assign ifa.addr = addr;  assign ifa.din = din;
    assign ifb.ce = ce;  assign ifb.we = we;  assign ifb.addr = addr;  assign ifb.din = din;

    rambyte_init #(.DW(32), .AW(4), .BW(8), .MODE("READFIRST"), .OREG(0), .CLEAR(1)) dut_a (
        .clk(clk), .nreset(nreset), .bus(ifa));

    rambyte_init #(.DW(32), .AW(4), .BW(8), .MODE("WRITEFIRST"), .OREG(1), .CLEAR(1)) dut_b (
        .clk(clk), .nreset(nreset), .bus(ifb));

    typedef struct {
        logic [31:0] data;
        int          due;
    } sb_t;

    sb_t sbq [2][$];

    typedef struct {
        logic        ce;
        logic [3:0]  we;
        logic [3:0]  addr;
        logic [31:0] din;
        logic [31:0] exp_rf;
        logic [31:0] exp_wf;
    } vec_t;

    vec_t vt [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic mon(input int d, input logic dv, input logic [31:0] dq, input logic bz);
        sb_t  e;
        logic exp_dv;
        if (!nreset) begin
            sbq[d].delete();
            last_dout[d] = '0;
            return;
        end
        exp_dv = (sbq[d].size() > 0) && (sbq[d][0].due == cyc);
        chk($sformatf("dut%0d_dvalid_cyc%0d", d, cyc), {31'd0, dv}, {31'd0, exp_dv});
        if (dv) pulses[d]++;
        if (dv && exp_dv) chk($sformatf("dut%0d_dout_cyc%0d", d, cyc), dq, sbq[d][0].data);
        else if (!dv)     chk($sformatf("dut%0d_hold_cyc%0d", d, cyc), dq, last_dout[d]);
        if (sbq[d].size() > 0 && (dv || sbq[d][0].due <= cyc)) void'(sbq[d].pop_front());
        last_dout[d] = dq;
        if (ce && !bz) begin
            e.data = exp_cur[d];
            e.due  = cyc + ((d == 0) ? 1 : 2);
            sbq[d].push_back(e);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        mon(0, ifa.dvalid, ifa.dout, ifa.busy);
        mon(1, ifb.dvalid, ifb.dout, ifb.busy);
    end

    task automatic req(input logic c, input logic [3:0] w, input logic [3:0] a,
                       input logic [31:0] dt, input logic [31:0] e0, input logic [31:0] e1);
        @(posedge clk); #1;
        ce = c; we = w; addr = a; din = dt;
        exp_cur[0] = e0; exp_cur[1] = e1;
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        ce = 1'b0; we = '0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Counts busy cycles from release; optionally pokes a request or pulls reset mid-clear.
    task automatic run_clear(input int inject_at, input int abort_at, output int na, output int nb);
        na = 0; nb = 0;
        for (int i = 0; i < 60; i++) begin
            if (ifa.busy) na++;
            if (ifb.busy) nb++;
            if (!ifa.busy && !ifb.busy) break;
            if (i + 1 == abort_at) begin
                nreset = 1'b0;
                #1;
                chk("abort_busy_a", {31'd0, ifa.busy}, 32'd1);
                chk("abort_busy_b", {31'd0, ifb.busy}, 32'd1);
                chk("abort_dout_a", ifa.dout, 32'd0);
                chk("abort_dout_b", ifb.dout, 32'd0);
                return;
            end
            ce = (i + 1 == inject_at);
            we = 4'hF; addr = 4'd5; din = 32'hFFFF_FFFF;
            exp_cur[0] = '0; exp_cur[1] = '0;
            @(posedge clk); #1;
        end
        ce = 1'b0; we = '0;
    endtask

    function automatic logic [31:0] content(input logic [3:0] a);
        case (a)
            4'd0:    return 32'h0000_FFFF;
            4'd3:    return 32'h12BB_56DD;
            4'd5:    return 32'h2222_2222;
            4'd15:   return 32'hCA00_0000;
            default: return 32'h0000_0000;
        endcase
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int na, nb, p0, p1;
        vt[0]  = '{1'b1, 4'b0101, 4'd3,  32'hAABB_CCDD, 32'h0000_0000, 32'h00BB_00DD};
        vt[1]  = '{1'b1, 4'b0000, 4'd3,  32'h0000_0000, 32'h00BB_00DD, 32'h00BB_00DD};
        vt[2]  = '{1'b1, 4'b1111, 4'd5,  32'h1111_1111, 32'h0000_0000, 32'h1111_1111};
        vt[3]  = '{1'b1, 4'b1111, 4'd5,  32'h2222_2222, 32'h1111_1111, 32'h2222_2222};
        vt[4]  = '{1'b1, 4'b0000, 4'd5,  32'h0000_0000, 32'h2222_2222, 32'h2222_2222};
        vt[5]  = '{1'b1, 4'b1010, 4'd3,  32'h1234_5678, 32'h00BB_00DD, 32'h12BB_56DD};
        vt[6]  = '{1'b1, 4'b0000, 4'd3,  32'h0000_0000, 32'h12BB_56DD, 32'h12BB_56DD};
        vt[7]  = '{1'b1, 4'b0000, 4'd15, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0000};
        vt[8]  = '{1'b1, 4'b1000, 4'd15, 32'hCAFE_F00D, 32'h0000_0000, 32'hCA00_0000};
        vt[9]  = '{1'b1, 4'b0000, 4'd15, 32'h0000_0000, 32'hCA00_0000, 32'hCA00_0000};
        vt[10] = '{1'b0, 4'b1111, 4'd15, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
        vt[11] = '{1'b1, 4'b0000, 4'd15, 32'h0000_0000, 32'hCA00_0000, 32'hCA00_0000};
        vt[12] = '{1'b1, 4'b0011, 4'd0,  32'h0000_FFFF, 32'h0000_0000, 32'h0000_FFFF};
        vt[13] = '{1'b1, 4'b0000, 4'd0,  32'h0000_0000, 32'h0000_FFFF, 32'h0000_FFFF};

        nreset = 1'b0; ce = 1'b0; we = '0; addr = '0; din = '0;
        exp_cur[0] = '0; exp_cur[1] = '0;
        pulses[0] = 0; pulses[1] = 0;
        last_dout[0] = '0; last_dout[1] = '0;

        repeat (3) @(posedge clk);
        #2;
        chk("rst_dout_a",   ifa.dout, 32'd0);
        chk("rst_dout_b",   ifb.dout, 32'd0);
        chk("rst_dvalid_a", {31'd0, ifa.dvalid}, 32'd0);
        chk("rst_dvalid_b", {31'd0, ifb.dvalid}, 32'd0);
        chk("rst_busy_a",   {31'd0, ifa.busy}, 32'd1);
        chk("rst_busy_b",   {31'd0, ifb.busy}, 32'd1);

        @(posedge clk); #1;
        nreset = 1'b1;
        #1;
        run_clear(5, 0, na, nb);
        chk("clear_cycles_a", na, 32'd16);
        chk("clear_cycles_b", nb, 32'd16);
        chk("clear_pulses_a", pulses[0], 32'd0);
        chk("clear_pulses_b", pulses[1], 32'd0);

        for (int a = 0; a < 16; a++) req(1'b1, 4'h0, 4'(a), 32'd0, 32'd0, 32'd0);

        for (int i = 0; i < 14; i++)
            req(vt[i].ce, vt[i].we, vt[i].addr, vt[i].din, vt[i].exp_rf, vt[i].exp_wf);
        idle(5);
        chk("drain_a", sbq[0].size(), 32'd0);
        chk("drain_b", sbq[1].size(), 32'd0);

        p0 = pulses[0]; p1 = pulses[1];
        for (int a = 0; a < 16; a++) req(1'b1, 4'h0, 4'(a), 32'd0, content(4'(a)), content(4'(a)));
        idle(5);
        chk("burst_pulses_a", pulses[0] - p0, 32'd16);
        chk("burst_pulses_b", pulses[1] - p1, 32'd16);

        req(1'b1, 4'h0, 4'd3, 32'd0, content(4'd3), content(4'd3));
        @(posedge clk); #1;
        ce = 1'b0;
        #1;
        nreset = 1'b0;
        #1;
        chk("midpipe_dout_a",   ifa.dout, 32'd0);
        chk("midpipe_dout_b",   ifb.dout, 32'd0);
        chk("midpipe_dvalid_a", {31'd0, ifa.dvalid}, 32'd0);
        chk("midpipe_dvalid_b", {31'd0, ifb.dvalid}, 32'd0);
        chk("midpipe_busy_a",   {31'd0, ifa.busy}, 32'd1);

        repeat (2) @(posedge clk); #1;
        nreset = 1'b1;
        #1;
        run_clear(0, 8, na, nb);
        chk("abort_at_a", na, 32'd8);
        @(posedge clk); #1;
        nreset = 1'b1;
        #1;
        run_clear(0, 0, na, nb);
        chk("reclear_cycles_a", na, 32'd16);
        chk("reclear_cycles_b", nb, 32'd16);

        req(1'b1, 4'h0, 4'd0,  32'd0, 32'd0, 32'd0);
        req(1'b1, 4'h0, 4'd3,  32'd0, 32'd0, 32'd0);
        req(1'b1, 4'h0, 4'd5,  32'd0, 32'd0, 32'd0);
        req(1'b1, 4'h0, 4'd15, 32'd0, 32'd0, 32'd0);
        idle(5);
        chk("final_drain_a", sbq[0].size(), 32'd0);
        chk("final_drain_b", sbq[1].size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rambyte_init.md
RAMBYTE_INIT -- requirements
Module: rambyte_init

Interface
REQ-001 SHALL have parameter DW, default 32: memory word width in bits.
REQ-002 SHALL have parameter AW, default 10: address width; depth is 2**AW.
REQ-003 SHALL have parameter BW, default 8: write-mask lane width in bits; DW SHALL be an integer multiple of BW.
REQ-004 SHALL have parameter MODE, default "READFIRST": read-during-write mode, either "READFIRST" or "WRITEFIRST".
REQ-005 SHALL have parameter OREG, default 0: when 1, one extra output register stage is added.
REQ-006 SHALL have parameter CLEAR, default 1: when 1, hardware zero-initialisation runs after reset.
REQ-007 clk  input  1  single clock; all logic on its rising edge.
REQ-008 nreset  input  1  asynchronous, active-low reset.
REQ-009 ce  input  1  chip enable; the request is accepted when ce=1 and busy=0.
REQ-010 we  input  DW/BW  per-lane write mask.
REQ-011 addr  input  AW  access address.
REQ-012 din  input  DW  write data.
REQ-013 dout  output  DW  read data.
REQ-014 dvalid  output  1  one-cycle pulse marking new dout.
REQ-015 busy  output  1  high while clearing; requests are ignored.

Function
REQ-016 States SHALL be CLR and RDY; reset enters CLR if CLEAR=1, otherwise RDY.
REQ-017 CLR: one word per cycle, address counter 0 to 2**AW-1, all lanes written with zero; busy=1.
REQ-018 CLR to RDY SHALL occur on the edge that writes address 2**AW-1; busy=0 from the next cycle; no wrap.
REQ-019 CLR takes exactly 2**AW cycles after nreset deasserts.
REQ-020 In CLR, ce/we/addr/din SHALL be ignored: no array write, no read, no dvalid.
REQ-021 Accepted write: each lane i with we[i]=1 stores din[i*BW+:BW]; lanes with we[i]=0 keep their value.
REQ-022 Every accepted request, including writes, SHALL return a read of addr.
REQ-023 READFIRST: the returned word is the pre-write content.
REQ-024 WRITEFIRST: the returned word is the post-write merge (new lanes where we=1, old lanes elsewhere).
REQ-025 Latency accept to dout/dvalid: 1 cycle if OREG=0, 2 cycles if OREG=1; back-to-back accepts every cycle.
REQ-026 dvalid=1 exactly in the cycle dout first shows the result; dout holds its value otherwise.
REQ-027 ce=1 with we all zero is a pure read; ce=0 causes no array, dout or dvalid change.
REQ-028 With OREG=1, the pipeline valid bit SHALL propagate with data; no request is dropped or duplicated.

Reset
REQ-029 nreset low SHALL asynchronously set dout=0, dvalid=0, pipeline valids=0, counter=0, busy=CLEAR.
REQ-030 Reset mid-CLR restarts clearing from address 0; reset mid-pipeline discards in-flight reads.
REQ-031 The array itself has no reset; its contents are defined only after CLR completes (or by writes when CLEAR=0).

Structure
REQ-032 Package rambyte_pkg SHALL hold the state enum (CLR, RDY) and the MODE string constants.
REQ-033 Sub-module rambyte_clr SHALL contain the clear FSM and counter, outputting busy, clear address and clear write strobe.
REQ-034 The array SHALL be a generic reg array with a per-lane write loop, with no vendor macros.

Verification (DW=32, AW=4, BW=8)
REQ-035 Reset release, CLEAR=1: busy=1 for 16 cycles, then 0; reading all 16 addresses returns 0x00000000.
REQ-036 Write 0xAABBCCDD, we=4'b0101, to address 3 after clear, then read address 3: dout=0x00BB00DD, dvalid pulse 1 cycle after the read (2 with OREG=1).
REQ-037 READFIRST: address 5 holds 0x11111111; write 0x22222222 with we=4'hF returns 0x11111111; WRITEFIRST returns 0x22222222.
REQ-038 Assert ce with we=4'hF during CLR at cycle 5: no write occurs, dvalid stays 0, and address 5 reads 0 after clear.
REQ-039 Pull nreset low at clear cycle 8: dout=0 and busy=1 immediately; after release, busy lasts 16 more cycles.
REQ-040 Back-to-back reads of addresses 0..15 with OREG=1: 16 consecutive dvalid pulses in order, with none lost.
